// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Execute-stage branch resolution. It decides whether a branch is taken and
//   computes target = curr_pc + 1 + ext(branch_offset). A taken branch raises a
//   registered redirect that is held until fetch accepts it. The unit then
//   flushes the wrong-path shadow for FLUSH_CYCLES cycles. It also keeps a
//   saturating count of taken branches.
// Ports
//   clk, rst        rising-edge clock; synchronous active-high reset
//   br_valid        opcode/cmp_eq/cmp_lt/curr_pc/branch_offset valid
//   opcode          6=BEQ 7=BNE 8=BLT 9=BGE 10=JMP, others not a branch
//   cmp_eq, cmp_lt  comparator flags (equal, signed less-than)
//   curr_pc         PC of the branch instruction
//   branch_offset   offset relative to curr_pc+1
//   redirect_ready  fetch accepts pc_load_val this cycle
//   pc_load_en      registered redirect request
//   pc_load_val     registered redirect target, stable while pc_load_en=1
//   flush           squash wrong-path instructions in fetch/decode
//   busy            unit not idle; br_valid is ignored while set
//   taken_count     saturating taken-branch count
module branch_redirect_unit #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned OFF_W        = 4,
  parameter int unsigned SIGNED_OFF   = 0,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [3:0]       opcode,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic [PC_W-1:0]  curr_pc,
  input  logic [OFF_W-1:0] branch_offset,
  input  logic             redirect_ready,
  output logic             pc_load_en,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [3:0] OP_BEQ = 4'd6;
  localparam logic [3:0] OP_BNE = 4'd7;
  localparam logic [3:0] OP_BLT = 4'd8;
  localparam logic [3:0] OP_BGE = 4'd9;
  localparam logic [3:0] OP_JMP = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIRECT,
    S_FLUSH
  } state_t;

  state_t            state;
  logic [3:0]        flush_cnt;
  logic              taken;
  logic [PC_W-1:0]   ext_off;
  logic [PC_W-1:0]   target;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = cmp_eq;
      OP_BNE:  taken = !cmp_eq;
      OP_BLT:  taken = cmp_lt;
      OP_BGE:  taken = !cmp_lt;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // The upper bits are filled bit by bit so that OFF_W == PC_W needs no
  // special case.
  always_comb begin
    ext_off = '0;
    ext_off[OFF_W-1:0] = branch_offset;
    for (int unsigned i = OFF_W; i < PC_W; i++) begin
      ext_off[i] = (SIGNED_OFF != 0) && branch_offset[OFF_W-1];
    end
  end

  assign target = curr_pc + PC_W'(1) + ext_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      flush_cnt   <= '0;
      pc_load_en  <= 1'b0;
      pc_load_val <= '0;
      flush       <= 1'b0;
      busy        <= 1'b0;
      taken_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_valid && taken) begin
            pc_load_val <= target;
            pc_load_en  <= 1'b1;
            flush       <= 1'b1;
            busy        <= 1'b1;
            if (taken_count != '1) begin
              taken_count <= taken_count + CNT_W'(1);
            end
            state <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            pc_load_en <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              flush <= 1'b0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              flush_cnt <= 4'(FLUSH_CYCLES);
              state     <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The counter is loaded with FLUSH_CYCLES and the unit leaves at 1,
          // so it stays exactly FLUSH_CYCLES cycles in this state.
          if (flush_cnt == 4'd1) begin
            flush_cnt <= '0;
            flush     <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [3:0]  opcode;
  logic        cmp_eq;
  logic        cmp_lt;
  logic [31:0] curr_pc;
  logic [3:0]  branch_offset;
  logic        redirect_ready;

  // default instance
  logic        en_d, fl_d, busy_d;
  logic [31:0] val_d;
  logic [15:0] cnt_d;
  // SIGNED_OFF=1
  logic        en_s, fl_s, busy_s;
  logic [31:0] val_s;
  logic [15:0] cnt_s;
  // CNT_W=2
  logic        en_c, fl_c, busy_c;
  logic [31:0] val_c;
  logic [1:0]  cnt_c;
  // FLUSH_CYCLES=0
  logic        en_z, fl_z, busy_z;
  logic [31:0] val_z;
  logic [15:0] cnt_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_unit dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .opcode(opcode), .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt), .curr_pc(curr_pc), .branch_offset(branch_offset),
    .redirect_ready(redirect_ready), .pc_load_en(en_d), .pc_load_val(val_d),
    .flush(fl_d), .busy(busy_d), .taken_count(cnt_d));

  branch_redirect_unit #(.SIGNED_OFF(1)) dut_s (
    .clk(clk), .rst(rst), .br_valid(br_valid), .opcode(opcode), .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt), .curr_pc(curr_pc), .branch_offset(branch_offset),
    .redirect_ready(redirect_ready), .pc_load_en(en_s), .pc_load_val(val_s),
    .flush(fl_s), .busy(busy_s), .taken_count(cnt_s));

  branch_redirect_unit #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .br_valid(br_valid), .opcode(opcode), .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt), .curr_pc(curr_pc), .branch_offset(branch_offset),
    .redirect_ready(redirect_ready), .pc_load_en(en_c), .pc_load_val(val_c),
    .flush(fl_c), .busy(busy_c), .taken_count(cnt_c));

  branch_redirect_unit #(.FLUSH_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .br_valid(br_valid), .opcode(opcode), .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt), .curr_pc(curr_pc), .branch_offset(branch_offset),
    .redirect_ready(redirect_ready), .pc_load_en(en_z), .pc_load_val(val_z),
    .flush(fl_z), .busy(busy_z), .taken_count(cnt_z));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    br_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_br(input logic [3:0] op, input logic eq, input logic lt,
                          input logic [31:0] pc, input logic [3:0] off);
    br_valid = 1'b1;
    opcode = op;
    cmp_eq = eq;
    cmp_lt = lt;
    curr_pc = pc;
    branch_offset = off;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (en_d !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", en_d); end
    checks++; if (val_d !== 32'h0) begin errors++; $display("FAIL reset_val: got %h expected 0", val_d); end
    checks++; if (fl_d !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b expected 0", fl_d); end
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_d); end
    checks++; if (cnt_d !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_d); end
  endtask

  task automatic test_beq_taken;
    do_reset();
    redirect_ready = 1'b1;
    drive_br(4'd6, 1'b1, 1'b0, 32'h100, 4'd3);
    tick();
    br_valid = 1'b0;
    checks++; if (en_d !== 1'b1) begin errors++; $display("FAIL beq_en: got %0b expected 1", en_d); end
    checks++; if (val_d !== 32'h104) begin errors++; $display("FAIL beq_val: got %h expected 104", val_d); end
    checks++; if (fl_d !== 1'b1) begin errors++; $display("FAIL beq_flush1: got %0b expected 1", fl_d); end
    checks++; if (busy_d !== 1'b1) begin errors++; $display("FAIL beq_busy: got %0b expected 1", busy_d); end
    checks++; if (cnt_d !== 16'd1) begin errors++; $display("FAIL beq_cnt: got %0d expected 1", cnt_d); end
    tick();
    checks++; if (en_d !== 1'b0) begin errors++; $display("FAIL beq_en_drop: got %0b expected 0", en_d); end
    checks++; if (fl_d !== 1'b1) begin errors++; $display("FAIL beq_flush2: got %0b expected 1", fl_d); end
    checks++; if (fl_z !== 1'b0 || busy_z !== 1'b0) begin errors++; $display("FAIL f0_idle: got flush %0b busy %0b expected 0 0", fl_z, busy_z); end
    tick();
    checks++; if (fl_d !== 1'b1 || busy_d !== 1'b1) begin errors++; $display("FAIL beq_flush3: got flush %0b busy %0b expected 1 1", fl_d, busy_d); end
    tick();
    checks++; if (fl_d !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL beq_flush_end: got flush %0b busy %0b expected 0 0", fl_d, busy_d); end
    checks++; if (val_d !== 32'h104) begin errors++; $display("FAIL beq_val_hold: got %h expected 104", val_d); end
  endtask

  task automatic test_not_taken;
    do_reset();
    redirect_ready = 1'b1;
    drive_br(4'd7, 1'b1, 1'b0, 32'h200, 4'd5);
    tick();
    checks++; if (en_d !== 1'b0 || busy_d !== 1'b0 || fl_d !== 1'b0) begin errors++; $display("FAIL bne_nt: got en %0b busy %0b flush %0b expected 0 0 0", en_d, busy_d, fl_d); end
    checks++; if (cnt_d !== 16'd0) begin errors++; $display("FAIL bne_nt_cnt: got %0d expected 0", cnt_d); end
    drive_br(4'd5, 1'b1, 1'b1, 32'h200, 4'd5);
    tick();
    checks++; if (en_d !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL nonbranch: got en %0b busy %0b expected 0 0", en_d, busy_d); end
    drive_br(4'd10, 1'b0, 1'b0, 32'h200, 4'd5);
    br_valid = 1'b0;
    tick();
    checks++; if (en_d !== 1'b0 || cnt_d !== 16'd0) begin errors++; $display("FAIL jmp_invalid: got en %0b cnt %0d expected 0 0", en_d, cnt_d); end
  endtask

  task automatic test_backpressure;
    do_reset();
    redirect_ready = 1'b0;
    drive_br(4'd10, 1'b0, 1'b0, 32'h20, 4'd1);
    tick();
    // wrong-path taken branches presented while busy
    drive_br(4'd6, 1'b1, 1'b0, 32'h900, 4'd0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (en_d !== 1'b1 || val_d !== 32'h22) begin errors++; $display("FAIL bp_hold%0d: got en %0b val %h expected 1 22", i, en_d, val_d); end
      if (i < 4) tick();
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checks++; if (en_d !== 1'b0 || fl_d !== 1'b1) begin errors++; $display("FAIL bp_accept: got en %0b flush %0b expected 0 1", en_d, fl_d); end
    tick();
    tick();
    br_valid = 1'b0;
    checks++; if (busy_d !== 1'b0 || cnt_d !== 16'd1 || val_d !== 32'h22) begin errors++; $display("FAIL bp_ignored: got busy %0b cnt %0d val %h expected 0 1 22", busy_d, cnt_d, val_d); end
    tick();
    checks++; if (en_d !== 1'b0 || cnt_d !== 16'd1) begin errors++; $display("FAIL bp_idle: got en %0b cnt %0d expected 0 1", en_d, cnt_d); end
  endtask

  task automatic test_cond_table;
    logic [3:0]  t_op  [7] = '{4'd8, 4'd8, 4'd9, 4'd9, 4'd6, 4'd7, 4'd11};
    logic        t_eq  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t_lt  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_pc  [7] = '{32'h40, 32'h50, 32'h60, 32'h70, 32'h80, 32'h90, 32'hA0};
    logic [3:0]  t_off [7] = '{4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0};
    logic        t_tk  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_val [7] = '{32'h43, 32'h43, 32'h65, 32'h65, 32'h65, 32'h91, 32'h91};
    logic [15:0] t_cnt [7] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3};
    do_reset();
    redirect_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_br(t_op[i], t_eq[i], t_lt[i], t_pc[i], t_off[i]);
      tick();
      br_valid = 1'b0;
      checks++;
      if (en_d !== t_tk[i] || val_d !== t_val[i] || cnt_d !== t_cnt[i]) begin
        errors++;
        $display("FAIL cond%0d: got en %0b val %h cnt %0d expected %0b %h %0d",
                 i, en_d, val_d, cnt_d, t_tk[i], t_val[i], t_cnt[i]);
      end
      tick(); tick(); tick();
    end
  endtask

  task automatic test_signed_wrap;
    do_reset();
    redirect_ready = 1'b1;
    drive_br(4'd10, 1'b0, 1'b0, 32'h0, 4'hE);
    tick();
    br_valid = 1'b0;
    checks++; if (val_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed_wrap: got %h expected ffffffff", val_s); end
    checks++; if (val_d !== 32'h0000_000F) begin errors++; $display("FAIL unsigned_ext: got %h expected 0000000f", val_d); end
    tick(); tick(); tick();
    drive_br(4'd10, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0);
    tick();
    br_valid = 1'b0;
    checks++; if (val_d !== 32'h0 || val_s !== 32'h0) begin errors++; $display("FAIL top_wrap: got %h %h expected 0 0", val_d, val_s); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    redirect_ready = 1'b0;
    drive_br(4'd10, 1'b0, 1'b0, 32'h300, 4'd1);
    tick();
    br_valid = 1'b0;
    checks++; if (en_d !== 1'b1) begin errors++; $display("FAIL mid_pre: got en %0b expected 1", en_d); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (en_d !== 1'b0 || val_d !== 32'h0 || fl_d !== 1'b0 || busy_d !== 1'b0 || cnt_d !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got en %0b val %h flush %0b busy %0b cnt %0d expected all 0", en_d, val_d, fl_d, busy_d, cnt_d);
    end
    redirect_ready = 1'b1;
    drive_br(4'd6, 1'b1, 1'b0, 32'h10, 4'd0);
    tick();
    br_valid = 1'b0;
    checks++; if (en_d !== 1'b1 || val_d !== 32'h11 || cnt_d !== 16'd1) begin errors++; $display("FAIL mid_after: got en %0b val %h cnt %0d expected 1 11 1", en_d, val_d, cnt_d); end
    tick(); tick(); tick();
  endtask

  task automatic test_saturation;
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    redirect_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_br(4'd10, 1'b0, 1'b0, 32'h1000, 4'd0);
      tick();
      br_valid = 1'b0;
      checks++; if (cnt_c !== exp_c[i]) begin errors++; $display("FAIL sat%0d: got %0d expected %0d", i, cnt_c, exp_c[i]); end
      tick(); tick(); tick();
    end
    checks++; if (cnt_d !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d expected 5", cnt_d); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    redirect_ready = 1'b1;
    drive_br(4'd10, 1'b0, 1'b0, 32'h500, 4'd0);
    tick();
    curr_pc = 32'h600;
    tick(); tick(); tick();
    checks++; if (busy_d !== 1'b0 || cnt_d !== 16'd1 || val_d !== 32'h501) begin errors++; $display("FAIL b2b_first: got busy %0b cnt %0d val %h expected 0 1 501", busy_d, cnt_d, val_d); end
    tick();
    br_valid = 1'b0;
    checks++; if (en_d !== 1'b1 || val_d !== 32'h601 || cnt_d !== 16'd2) begin errors++; $display("FAIL b2b_second: got en %0b val %h cnt %0d expected 1 601 2", en_d, val_d, cnt_d); end
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    br_valid = 1'b0;
    opcode = 4'd0;
    cmp_eq = 1'b0;
    cmp_lt = 1'b0;
    curr_pc = 32'h0;
    branch_offset = 4'd0;
    redirect_ready = 1'b0;
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_backpressure();
    test_cond_table();
    test_signed_wrap();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
